// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, slice-offset helpers and FSM state for the convolution PE
package pe_pkg;

   typedef enum logic {
      COMPUTE = 1'b0,
      DONE    = 1'b1
   } state_t;

   function automatic int out_dim(input int t, input int k);
      return t - k;
   endfunction

   function automatic int n_out(input int t, input int k);
      return (t - k) * (t - k);
   endfunction

   function automatic int acc_w(input int kw, input int iw);
      return kw + iw + 8;
   endfunction

   // Row-major within a channel, first element at the MSB end of that channel's slice.
   function automatic int kernel_off(input int ch, input int r, input int j,
                                     input int k, input int kw);
      return (ch * k * k + k * k - 1 - (r * k + j)) * kw;
   endfunction

   function automatic int input_off(input int ch, input int r, input int j,
                                    input int t, input int iw);
      return (ch * t * t + t * t - 1 - (r * t + j)) * iw;
   endfunction

   function automatic int output_off(input int y, input int x,
                                     input int od, input int aw);
      return (y * od + x) * aw;
   endfunction

endpackage

// File: rtl/pe_mac_window.sv
// rtl/pe_mac_window.sv - combinational K*K signed dot product of one channel window at (Y,X)
module pe_mac_window
   import pe_pkg::*;
#(
   parameter int K     = 3,
   parameter int T     = 4,
   parameter int IW    = 8,
   parameter int KW    = 8,
   parameter int ACC_W = 24,
   parameter int Y     = 0,
   parameter int X     = 0
) (
   input  logic [K*K*KW-1:0] kern,
   input  logic [T*T*IW-1:0] tile,
   output logic [ACC_W-1:0]  dot
);

   logic signed [KW-1:0]    kv;
   logic signed [IW-1:0]    iv;
   logic signed [KW+IW-1:0] prod;
   logic [ACC_W-1:0]        sum;

   always_comb begin
      kv   = '0;
      iv   = '0;
      prod = '0;
      sum  = '0;
      for (int r = 0; r < K; r++) begin
         for (int j = 0; j < K; j++) begin
            kv   = kern[kernel_off(0, r, j, K, KW) +: KW];
            iv   = tile[input_off(0, Y + r, X + j, T, IW) +: IW];
            prod = kv * iv;
            sum  = sum + {{(ACC_W-KW-IW){prod[KW+IW-1]}}, prod};
         end
      end
      dot = sum;
   end

endmodule

// File: rtl/pe.sv
// rtl/pe.sv - tiled multi-channel convolution PE, one channel per clock; PE_RELU_EN clamps negative results on DONE entry
module pe
   import pe_pkg::*;
#(
   parameter int KERNEL_SIZE       = 3,
   parameter int INPUT_TILE_SIZE   = 4,
   parameter int INPUT_DATA_WIDTH  = 8,
   parameter int KERNEL_DATA_WIDTH = 8,
   parameter int CHANNELS          = 3
) (
   input  logic                                                   clk,
   input  logic                                                   reset,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH*CHANNELS-1:0] Kernel,
   input  logic [INPUT_TILE_SIZE*INPUT_TILE_SIZE*INPUT_DATA_WIDTH*CHANNELS-1:0] inpData,
   output logic [n_out(INPUT_TILE_SIZE, KERNEL_SIZE)*acc_w(KERNEL_DATA_WIDTH, INPUT_DATA_WIDTH)-1:0] outData,
   output logic                                                   finalCompute
);

   localparam int K   = KERNEL_SIZE;
   localparam int T   = INPUT_TILE_SIZE;
   localparam int IW  = INPUT_DATA_WIDTH;
   localparam int KW  = KERNEL_DATA_WIDTH;
   localparam int OD  = out_dim(T, K);
   localparam int NO  = n_out(T, K);
   localparam int AW  = acc_w(KW, IW);
   localparam int KSL = K * K * KW;
   localparam int ISL = T * T * IW;
   localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   state_t          state_q, state_d;
   logic [CW-1:0]   ch;
   logic            last;
   logic            relu_zero;
   logic [KSL-1:0]  kern_ch;
   logic [ISL-1:0]  tile_ch;
   logic [AW-1:0]   acc    [NO];
   logic [AW-1:0]   dot    [NO];
   logic [AW-1:0]   acc_nx [NO];

`ifdef PE_RELU_EN
   assign relu_zero = 1'b1;
`else
   assign relu_zero = 1'b0;
`endif

   assign last = (ch == CW'(CHANNELS - 1));

   // Constant-index mux keeps every slice select in range for any ch value.
   always_comb begin
      kern_ch = '0;
      tile_ch = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (ch == CW'(c)) begin
            kern_ch = Kernel[c*KSL +: KSL];
            tile_ch = inpData[c*ISL +: ISL];
         end
      end
   end

   for (genvar y = 0; y < OD; y++) begin : g_row
      for (genvar x = 0; x < OD; x++) begin : g_col
         pe_mac_window #(
            .K     (K),
            .T     (T),
            .IW    (IW),
            .KW    (KW),
            .ACC_W (AW),
            .Y     (y),
            .X     (x)
         ) u_mac (
            .kern (kern_ch),
            .tile (tile_ch),
            .dot  (dot[y*OD+x])
         );
         assign outData[output_off(y, x, OD, AW) +: AW] = acc[y*OD+x];
      end
   end

   always_comb begin
      for (int i = 0; i < NO; i++) begin
         acc_nx[i] = acc[i] + dot[i];
         if (relu_zero && last && acc_nx[i][AW-1]) begin
            acc_nx[i] = '0;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      finalCompute = 1'b0;
      case (state_q)
         COMPUTE: if (last) state_d = DONE;
         DONE:    finalCompute = 1'b1;
         default: state_d = COMPUTE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= COMPUTE;
         ch      <= '0;
         for (int i = 0; i < NO; i++) acc[i] <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == COMPUTE) begin
            for (int i = 0; i < NO; i++) acc[i] <= acc_nx[i];
            if (!last) ch <= ch + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pe.sv
// tb/tb_pe.sv - scoreboard bench for pe: directed plan vectors plus randomized tiles against an arithmetic model
module tb_pe;

   localparam int K  = 3;
   localparam int T  = 4;
   localparam int IW = 8;
   localparam int KW = 8;
   localparam int C  = 3;
   localparam int OD = T - K;
   localparam int NO = OD * OD;
   localparam int AW = KW + IW + 8;
   localparam int OW = NO * AW;

   logic                  clk;
   logic                  reset;
   logic [C*K*K*KW-1:0]   Kernel;
   logic [C*T*T*IW-1:0]   inpData;
   logic [OW-1:0]         outData;
   logic                  finalCompute;

   int km [C][K][K];
   int im [C][T][T];

   logic [OW-1:0] exp_q [$];
   int vectors;
   int miscompares;

   pe #(
      .KERNEL_SIZE       (K),
      .INPUT_TILE_SIZE   (T),
      .INPUT_DATA_WIDTH  (IW),
      .KERNEL_DATA_WIDTH (KW),
      .CHANNELS          (C)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Kernel       (Kernel),
      .inpData      (inpData),
      .outData      (outData),
      .finalCompute (finalCompute)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic pack();
      for (int c = 0; c < C; c++) begin
         for (int r = 0; r < K; r++)
            for (int j = 0; j < K; j++)
               Kernel[(c*K*K + K*K-1-(r*K+j))*KW +: KW] = KW'(km[c][r][j]);
         for (int r = 0; r < T; r++)
            for (int j = 0; j < T; j++)
               inpData[(c*T*T + T*T-1-(r*T+j))*IW +: IW] = IW'(im[c][r][j]);
      end
   endtask

   function automatic logic [OW-1:0] model();
      logic [OW-1:0] e;
      logic [AW-1:0] w;
      int s;
      e = '0;
      for (int y = 0; y < OD; y++) begin
         for (int x = 0; x < OD; x++) begin
            s = 0;
            for (int c = 0; c < C; c++)
               for (int r = 0; r < K; r++)
                  for (int j = 0; j < K; j++)
                     s += km[c][r][j] * im[c][y+r][x+j];
            w = s[AW-1:0];
`ifdef PE_RELU_EN
            if (s < 0) w = '0;
`endif
            e[(y*OD+x)*AW +: AW] = w;
         end
      end
      return e;
   endfunction

   task automatic clear_all();
      for (int c = 0; c < C; c++) begin
         for (int r = 0; r < K; r++) for (int j = 0; j < K; j++) km[c][r][j] = 0;
         for (int r = 0; r < T; r++) for (int j = 0; j < T; j++) im[c][r][j] = 0;
      end
   endtask

   task automatic randomize_all();
      for (int c = 0; c < C; c++) begin
         for (int r = 0; r < K; r++)
            for (int j = 0; j < K; j++) km[c][r][j] = int'($urandom_range(255)) - 128;
         for (int r = 0; r < T; r++)
            for (int j = 0; j < T; j++) im[c][r][j] = int'($urandom_range(255)) - 128;
      end
   endtask

   task automatic run_vec(input bit mid_reset, input int mid_edge);
      logic [OW-1:0] e;
      @(negedge clk);
      reset = 1'b0;
      pack();
      e = model();
      @(posedge clk); #1;
      chk("reset_out", outData, '0);
      chk("reset_fc", OW'(finalCompute), '0);
      if (mid_reset) begin
         @(negedge clk);
         reset = 1'b1;
         repeat (mid_edge) @(posedge clk);
         #1;
         chk("mid_fc", OW'(finalCompute), '0);
         @(negedge clk);
         reset = 1'b0;
         @(posedge clk); #1;
         chk("mid_reset_out", outData, '0);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_q.push_back(e);
      for (int n = 1; n <= C; n++) begin
         @(posedge clk); #1;
         chk($sformatf("fc_edge%0d", n), OW'(finalCompute), OW'(n == C));
      end
      for (int h = 0; h < 10; h++) begin
         @(negedge clk);
         randomize_all();
         pack();
         @(posedge clk); #1;
         chk("hold_out", outData, e);
         chk("hold_fc", OW'(finalCompute), OW'(1));
      end
   endtask

   // Monitor: every rising finalCompute must match the oldest queued expectation.
   logic fc_prev;
   initial fc_prev = 1'b0;
   always @(negedge clk) begin
      if (finalCompute && !fc_prev) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got %0h required none", outData);
         end else begin
            chk("result", outData, exp_q.pop_front());
         end
      end
      fc_prev <= finalCompute;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      Kernel      = '0;
      inpData     = '0;
      repeat (2) @(posedge clk);

      clear_all();
      km[0][0][0] = 8; km[0][1][1] = 8; km[0][2][2] = 8;
      im[0][0] = '{1, 2, 3, 4};
      im[0][1] = '{-1, -2, -3, -4};
      im[0][2] = '{1, -2, 3, -4};
      im[0][3] = '{0, 0, 0, -1};
      for (int r = 0; r < K; r++) km[1][r] = '{8, 8, 16};
      for (int r = 0; r < T; r++) for (int j = 0; j < T; j++) im[1][r][j] = 1;
      km[2][0] = '{8, 0, 8}; km[2][1] = '{0, 8, 0}; km[2][2] = '{8, 0, 8};
      for (int r = 0; r < T; r++) for (int j = 0; j < T; j++) im[2][r][j] = r*T + j + 1;
      chk("plan_model_352", model(), OW'(352));
      run_vec(1'b0, 0);

      clear_all();
      km[0][0][0] = 8; km[0][1][1] = 8; km[0][2][2] = 8;
      im[0][0] = '{1, 2, 3, 4};
      im[0][1] = '{-1, -2, -3, -4};
      im[0][2] = '{1, -2, 3, -4};
      im[0][3] = '{0, 0, 0, -1};
      for (int r = 0; r < K; r++) km[1][r] = '{8, 8, 16};
      for (int r = 0; r < T; r++) for (int j = 0; j < T; j++) im[1][r][j] = 1;
      km[2][0] = '{8, 0, 8}; km[2][1] = '{0, 8, 0}; km[2][2] = '{8, 0, 8};
      for (int r = 0; r < T; r++) for (int j = 0; j < T; j++) im[2][r][j] = r*T + j + 1;
      run_vec(1'b1, 2);

      for (int c = 0; c < C; c++) begin
         for (int r = 0; r < K; r++) for (int j = 0; j < K; j++) km[c][r][j] = -128;
         for (int r = 0; r < T; r++) for (int j = 0; j < T; j++) im[c][r][j] = 127;
      end
`ifndef PE_RELU_EN
      chk("plan_model_extreme", model(), OW'(24'hF94D80));
`endif
      run_vec(1'b0, 0);

      clear_all();
      km[0][0][0] = 8;
      im[0][0][0] = -5;
      run_vec(1'b0, 0);

      for (int v = 0; v < 20; v++) begin
         randomize_all();
         run_vec($urandom_range(3) == 0, int'($urandom_range(C-1, 1)));
      end

      repeat (3) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_results: got %0d required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
